// File: rtl/serial_adder_fsm_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The controller side drives start/a/b; the adder side returns busy/done/sum/carry.
interface serial_adder_fsm_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, WIDTH cycles per add.
// Operands are captured on an accepted start; sum/carry update only at completion or reset.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_fsm_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic s_bit;
  logic c_next;

  // The single full-adder cell shared by every bit position.
  assign s_bit  = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign c_next = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    c_d      = c_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          sum_sr_d = '0;
          c_d      = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = {s_bit, sum_sr_q[WIDTH-1:1]};
        c_d      = c_next;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = {s_bit, sum_sr_q[WIDTH-1:1]};
          carry_d = c_next;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status flags are decoded from the next state so they leave dedicated flops.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      c_q      <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      c_q      <= c_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench for serial_adder_fsm: reset, single adds, ignored starts, mid-run reset,
// and a back-to-back stream with operands scrambled during each run.
module tb_serial_adder_fsm;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_fsm_if #(.WIDTH(W)) bus ();

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) check({tag, "_done_timeout"}, 32'(bus.done), 32'd1);
  endtask

  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] esum, input logic ecarry);
    int busy_cnt = 0;
    int n = 0;
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = b ^ 8'h5A;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_sum"}, 32'(bus.sum), 32'(esum));
    check({tag, "_carry"}, 32'(bus.carry), 32'(ecarry));
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    int last_done;

    vecs = '{
      '{8'h05, 8'h03, 8'h08, 1'b0},
      '{8'hFF, 8'h01, 8'h00, 1'b1},
      '{8'hFF, 8'hFF, 8'hFE, 1'b1},
      '{8'h0F, 8'h01, 8'h10, 1'b0},
      '{8'h80, 8'h80, 8'h00, 1'b1},
      '{8'h01, 8'h02, 8'h03, 1'b0},
      '{8'hAA, 8'h55, 8'hFF, 1'b0},
      '{8'h7F, 8'h01, 8'h80, 1'b0},
      '{8'hC8, 8'h64, 8'h2C, 1'b1},
      '{8'h00, 8'h00, 8'h00, 1'b0},
      '{8'h12, 8'h34, 8'h46, 1'b0},
      '{8'hF0, 8'h0F, 8'hFF, 1'b0},
      '{8'h99, 8'h99, 8'h32, 1'b1},
      '{8'h3C, 8'hC4, 8'h00, 1'b1}
    };

    // Reset held two cycles with start asserted.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_sum", 32'(bus.sum), 32'd0);
      check("rst_carry", 32'(bus.carry), 32'd0);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_rst_busy", 32'(bus.busy), 32'd0);
    check("idle_after_rst_done", 32'(bus.done), 32'd0);

    run_add("add_5_3", 8'h05, 8'h03, 8'h08, 1'b0);
    run_add("add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_add("add_ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);

    // Starts during RUN and DONE must be ignored.
    @(negedge clk);
    bus.a = 8'h0F; bus.b = 8'h01; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore");
    check("ignore_sum", 32'(bus.sum), 32'h10);
    check("ignore_carry", 32'(bus.carry), 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ignore_done_end", 32'(bus.done), 32'd0);
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    check("ignore_no_second_op", 32'(seen), 32'd0);
    check("ignore_sum_held", 32'(bus.sum), 32'h10);

    // Reset in the middle of a run discards it.
    @(negedge clk);
    bus.a = 8'h80; bus.b = 8'h80; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_carry", 32'(bus.carry), 32'd0);
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_add("add_01_02", 8'h01, 8'h02, 8'h03, 1'b0);

    // Back-to-back stream with start held high; operands scrambled once captured.
    last_done = 0;
    @(negedge clk);
    bus.a     = vecs[0].a;
    bus.b     = vecs[0].b;
    bus.start = 1'b1;
    for (int i = 0; i < NV; i++) begin
      n = 0;
      while (bus.busy !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (bus.busy !== 1'b1) check($sformatf("b2b_%0d_busy_timeout", i), 32'(bus.busy), 32'd1);
      bus.a = ~vecs[i].a;
      bus.b = vecs[i].b ^ 8'hC3;
      wait_done($sformatf("b2b_%0d", i));
      check($sformatf("b2b_%0d_sum", i), 32'(bus.sum), 32'(vecs[i].s));
      check($sformatf("b2b_%0d_carry", i), 32'(bus.carry), 32'(vecs[i].c));
      if (i > 0) check($sformatf("b2b_%0d_period", i), 32'(cyc - last_done), 32'(W + 2));
      last_done = cyc;
      if (i < NV - 1) begin
        bus.a = vecs[i + 1].a;
        bus.b = vecs[i + 1].b;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
